vga_scan_sink: RTL and testbench

- Raster timing generator and pixel sink for the pattern/fractal colour path.
- Scans screen coordinates (x, y) out to a combinational colour source, such as the test-pattern or fractal colour stage.
- Samples the returned r/g/b and drives registered VGA-style outputs: colour, hsync, vsync, data-enable.
- Sits between the colour generators and the board video PHY/encoder; it is the coordinate-issuing, pixel-consuming end of the x/y -> rgb interface.

---
 rtl/vga_scan_sink.sv | 142 ++++++++++++++
 tb/tb_vga_scan_sink.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_sink.sv
// vga_scan_sink: raster timing generator and pixel sink.
// Scans (x, y) out to a combinational colour source, samples the returned
// colour one pixel strobe later and drives registered VGA-style outputs.
//
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   pix_en              pixel strobe; all state advances only when 1
//   x, y                current raster counts (to the colour source)
//   in_r/in_g/in_b      colour returned for (x, y)
//   vga_r/vga_g/vga_b   registered colour, zero during blanking
//   vga_hs/vga_vs       registered syncs, asserted level SYNC_ACTIVE
//   vga_de              registered data-enable
//   frame_start         one-clk pulse aligned with output pixel (0,0)
//   frame_cnt           completed-frame counter (wraps)
module vga_scan_sink #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter logic        SYNC_ACTIVE = 1'b0,
    parameter int unsigned COORD_W     = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    input  logic [7:0]         in_r,
    input  logic [7:0]         in_g,
    input  logic [7:0]         in_b,
    output logic [7:0]         vga_r,
    output logic [7:0]         vga_g,
    output logic [7:0]         vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_de,
    output logic               frame_start,
    output logic [15:0]        frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] H_SYN_LO = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] H_SYN_HI = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] V_SYN_LO = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] V_SYN_HI = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] r_h_cnt;
    logic [COORD_W-1:0] r_v_cnt;
    logic [7:0]         r_r;
    logic [7:0]         r_g;
    logic [7:0]         r_b;
    logic               r_hs;
    logic               r_vs;
    logic               r_de;
    logic               r_fs;
    logic [15:0]        r_frame_cnt;

    logic               w_h_last;
    logic               w_v_last;
    logic               w_active;
    logic               w_hs;
    logic               w_vs;
    logic               w_origin;
    logic [COORD_W-1:0] w_h_nxt;
    logic [COORD_W-1:0] w_v_nxt;

    // Position decode and next-count computation from the current counts
    always_comb begin
        w_h_last = (r_h_cnt == H_LAST);
        w_v_last = (r_v_cnt == V_LAST);
        w_active = (r_h_cnt < H_ACT_C) && (r_v_cnt < V_ACT_C);
        w_hs     = ((r_h_cnt >= H_SYN_LO) && (r_h_cnt < H_SYN_HI)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        w_vs     = ((r_v_cnt >= V_SYN_LO) && (r_v_cnt < V_SYN_HI)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
        w_h_nxt  = w_h_last ? '0 : r_h_cnt + COORD_W'(1);
        w_v_nxt  = r_v_cnt;
        if (w_h_last) begin
            w_v_nxt = w_v_last ? '0 : r_v_cnt + COORD_W'(1);
        end
    end

    // Raster counters and completed-frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_frame_cnt <= '0;
        end else if (pix_en) begin
            r_h_cnt <= w_h_nxt;
            r_v_cnt <= w_v_nxt;
            if (w_h_last && w_v_last) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    // Output stage: one strobe behind the counts; colour gated to zero in blanking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r  <= '0;
            r_g  <= '0;
            r_b  <= '0;
            r_de <= 1'b0;
            r_hs <= ~SYNC_ACTIVE;
            r_vs <= ~SYNC_ACTIVE;
            r_fs <= 1'b0;
        end else if (pix_en) begin
            r_r  <= w_active ? in_r : 8'h00;
            r_g  <= w_active ? in_g : 8'h00;
            r_b  <= w_active ? in_b : 8'h00;
            r_de <= w_active;
            r_hs <= w_hs;
            r_vs <= w_vs;
            r_fs <= w_origin;
        end else begin
            // Stalled strobes must not stretch the frame marker
            r_fs <= 1'b0;
        end
    end

    assign x           = r_h_cnt;
    assign y           = r_v_cnt;
    assign vga_r       = r_r;
    assign vga_g       = r_g;
    assign vga_b       = r_b;
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign vga_de      = r_de;
    assign frame_start = r_fs;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_scan_sink.sv
// Bench for vga_scan_sink: small-raster instance checked pixel by pixel
// against a reference model via a scoreboard, plus a default-size instance
// checked over one full line.
module tb_vga_scan_sink;

    localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int unsigned VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;

    typedef struct packed {
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_en;
    logic        colour_ff;
    logic [9:0]  x, y;
    logic [7:0]  in_r, in_g, in_b;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_de, frame_start;
    logic [15:0] frame_cnt;

    logic [9:0]  d_x, d_y;
    logic [7:0]  d_r, d_g, d_b;
    logic        d_hs, d_vs, d_de, d_fs;
    logic [15:0] d_fc;

    exp_t        sb_q[$];
    exp_t        last_exp;
    int          m_h, m_v;
    logic [15:0] m_fc;
    int          n_checks = 0;
    int          n_errors = 0;
    int          st_de, st_hs, st_vs, st_fs, st_dde, st_dhs, st_dvs;

    always #5 clk = ~clk;

    // Combinational colour source fed from the DUT's own coordinates
    assign in_r = colour_ff ? 8'hFF : x[7:0];
    assign in_g = y[7:0];
    assign in_b = 8'h5A;

    vga_scan_sink #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACTIVE(1'b0), .COORD_W(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(x), .y(y),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    vga_scan_sink dut_d (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(d_x), .y(d_y),
        .in_r(8'h11), .in_g(8'h22), .in_b(8'h33),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
        .vga_hs(d_hs), .vga_vs(d_vs), .vga_de(d_de),
        .frame_start(d_fs), .frame_cnt(d_fc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_stats();
        st_de = 0; st_hs = 0; st_vs = 0; st_fs = 0;
        st_dde = 0; st_dhs = 0; st_dvs = 0;
    endtask

    // One clock: predict from the model, drive, then pop and compare
    task automatic tick(input logic en);
        exp_t e;
        logic act, hw, vw;
        pix_en = en;
        if (en) begin
            act  = (m_h < int'(HA)) && (m_v < int'(VA));
            hw   = (m_h >= int'(HA + HF)) && (m_h < int'(HA + HF + HS));
            vw   = (m_v >= int'(VA + VF)) && (m_v < int'(VA + VF + VS));
            e.de = act;
            e.hs = hw ? 1'b0 : 1'b1;
            e.vs = vw ? 1'b0 : 1'b1;
            e.r  = act ? (colour_ff ? 8'hFF : 8'(m_h)) : 8'h00;
            e.g  = act ? 8'(m_v) : 8'h00;
            e.b  = act ? 8'h5A : 8'h00;
            e.fs = (m_h == 0) && (m_v == 0);
            if (m_h == int'(HT) - 1 && m_v == int'(VT) - 1) m_fc = m_fc + 16'd1;
            e.fc = m_fc;
            if (m_h == int'(HT) - 1) begin
                m_h = 0;
                m_v = (m_v == int'(VT) - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end else begin
            e    = last_exp;
            e.fs = 1'b0;
        end
        sb_q.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("vga_de", 32'(vga_de), 32'(e.de));
        check("vga_hs", 32'(vga_hs), 32'(e.hs));
        check("vga_vs", 32'(vga_vs), 32'(e.vs));
        check("vga_r", 32'(vga_r), 32'(e.r));
        check("vga_g", 32'(vga_g), 32'(e.g));
        check("vga_b", 32'(vga_b), 32'(e.b));
        check("frame_start", 32'(frame_start), 32'(e.fs));
        check("frame_cnt", 32'(frame_cnt), 32'(e.fc));
        check("x", 32'(x), 32'(m_h));
        check("y", 32'(y), 32'(m_v));
        st_de  += int'(vga_de);
        st_hs  += int'(!vga_hs);
        st_vs  += int'(!vga_vs);
        st_fs  += int'(frame_start);
        st_dde += int'(d_de);
        st_dhs += int'(!d_hs);
        st_dvs += int'(!d_vs);
        @(negedge clk);
    endtask

    // Reset from a negedge; optionally check outputs go idle without a clock edge
    task automatic do_reset(input logic chk);
        rst_n = 1'b0;
        #1;
        if (chk) begin
            check("rst_hs", 32'(vga_hs), 32'd1);
            check("rst_vs", 32'(vga_vs), 32'd1);
            check("rst_de", 32'(vga_de), 32'd0);
            check("rst_rgb", {8'h00, vga_r, vga_g, vga_b}, 32'd0);
            check("rst_x", 32'(x), 32'd0);
            check("rst_y", 32'(y), 32'd0);
            check("rst_fs", 32'(frame_start), 32'd0);
            check("rst_fc", 32'(frame_cnt), 32'd0);
        end
        repeat (2) @(negedge clk);
        m_h = 0;
        m_v = 0;
        m_fc = 16'd0;
        last_exp = '{r: 8'h00, g: 8'h00, b: 8'h00, de: 1'b0, hs: 1'b1,
                     vs: 1'b1, fs: 1'b0, fc: 16'd0};
        sb_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        pix_en = 1'b0;
        colour_ff = 1'b0;
        @(negedge clk);
        do_reset(1'b1);

        // Full frame with coordinate-derived colour
        clear_stats();
        repeat (HT * VT) tick(1'b1);
        check("frame_de_count", 32'(st_de), 32'(HA * VA));
        check("frame_hs_count", 32'(st_hs), 32'(HS * VT));
        check("frame_vs_count", 32'(st_vs), 32'(VS * HT));
        check("frame_fs_count", 32'(st_fs), 32'd1);
        check("frame_cnt_1", 32'(frame_cnt), 32'd1);

        // Constant white source: blanking must still force zero
        colour_ff = 1'b1;
        repeat (HT * VT) tick(1'b1);
        check("frame_cnt_2", 32'(frame_cnt), 32'd2);
        colour_ff = 1'b0;

        // Strobe toggling starting at a frame origin
        clear_stats();
        for (int i = 0; i < 30; i++) begin
            tick(1'b1);
            tick(1'b0);
        end
        check("toggle_fs_count", 32'(st_fs), 32'd1);

        // Asynchronous reset mid-line at (5,2)
        guard = 0;
        while (!(m_h == 5 && m_v == 2) && guard < 200) begin
            tick(1'b1);
            guard++;
        end
        check("reach_5_2", 32'(guard < 200), 32'd1);
        do_reset(1'b1);
        clear_stats();
        repeat (20) tick(1'b1);
        check("restart_fs", 32'(st_fs), 32'd1);

        // Frame counter wrap from 65535
        do_reset(1'b0);
        force dut.r_frame_cnt = 16'hFFFF;
        #1;
        release dut.r_frame_cnt;
        m_fc = 16'hFFFF;
        last_exp.fc = 16'hFFFF;
        repeat (HT * VT) tick(1'b1);
        check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);

        // Default-size instance over one full line
        do_reset(1'b0);
        clear_stats();
        repeat (800) tick(1'b1);
        check("d_de_line", 32'(st_dde), 32'd640);
        check("d_hs_line", 32'(st_dhs), 32'd96);
        check("d_vs_line", 32'(st_dvs), 32'd0);
        check("d_x_wrap", 32'(d_x), 32'd0);
        check("d_y_next", 32'(d_y), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
